// File: rtl/chan_load_counter_pkg.sv
// Shared types for the channel load/count datapath: command encoding,
// output-stage states and the select-width derivation.
package chan_load_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_t;

    typedef enum logic {
        OST_EMPTY = 1'b0,
        OST_FULL  = 1'b1
    } ostate_t;

    // A single channel still needs one select bit so the port never collapses.
    function automatic int sel_width(input int channels);
        if (channels <= 2) begin
            return 1;
        end else begin
            return $clog2(channels);
        end
    endfunction

endpackage

// File: rtl/chan_load_counter_if.sv
// Command side and result side of chan_load_counter grouped in one bundle;
// the producer/consumer pair uses master, the datapath uses slave.
interface chan_load_counter_if
    import chan_load_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int SELW     = sel_width(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] psrc_data;
    logic [SELW-1:0]           psrc_sel;
    logic [1:0]                pmode;
    logic                      pin_valid;
    logic                      pin_ready;
    logic [WIDTH-1:0]          pout_data;
    logic [SELW-1:0]           pout_sel;
    logic                      pout_wrap;
    logic                      pout_err;
    logic                      pout_valid;
    logic                      pout_ready;

    modport master (
        output psrc_data, psrc_sel, pmode, pin_valid, pout_ready,
        input  pin_ready, pout_data, pout_sel, pout_wrap, pout_err, pout_valid
    );

    modport slave (
        input  psrc_data, psrc_sel, pmode, pin_valid, pout_ready,
        output pin_ready, pout_data, pout_sel, pout_wrap, pout_err, pout_valid
    );
endinterface

// File: rtl/chan_load_counter_select.sv
// Combinational CHANNELS-to-one source mux; an out-of-range select yields
// zero and raises oor_o.
module chan_select
    import chan_load_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] src_i,
    input  logic [SELW-1:0]           sel_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      oor_o
);
    localparam logic [SELW:0] CH_LIM = (SELW+1)'(CHANNELS);

    logic [WIDTH-1:0] chan_s [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan_s[k] = src_i[k*WIDTH +: WIDTH];
    end

    // Pick the selected channel or flag the select as out of range.
    always_comb begin
        data_o = {WIDTH{1'b0}};
        oor_o  = 1'b1;
        if ({1'b0, sel_i} < CH_LIM) begin
            data_o = chan_s[sel_i];
            oor_o  = 1'b0;
        end else begin
            data_o = {WIDTH{1'b0}};
            oor_o  = 1'b1;
        end
    end

endmodule

// File: rtl/chan_load_counter.sv
// Channel load / wrap counter with a one-entry valid/ready result stage.
// Each accepted command updates the accumulator and produces exactly one beat.
module chan_load_counter
    import chan_load_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 2,
    parameter logic [WIDTH-1:0] LIMIT    = {WIDTH{1'b1}},
    localparam int              SELW     = sel_width(CHANNELS)
) (
    input  logic                pclk,
    input  logic                prst_n,
    chan_load_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             wrap_d, err_d;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_oor_s;
    logic             pin_ready_s, accept_s;

    ostate_t          state_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;
    logic             out_wrap_q, out_err_q;

    chan_select #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_select (
        .src_i  (bus.psrc_data),
        .sel_i  (bus.psrc_sel),
        .data_o (sel_data_s),
        .oor_o  (sel_oor_s)
    );

    assign pin_ready_s = (state_q == OST_EMPTY) | bus.pout_ready;
    assign accept_s    = bus.pin_valid & pin_ready_s;

    // Next accumulator value and beat flags for the command on the inputs.
    always_comb begin
        acc_d  = acc_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        case (mode_t'(bus.pmode))
            MODE_HOLD: acc_d = acc_q;
            MODE_LOAD: begin
                acc_d = sel_data_s;
                err_d = sel_oor_s;
            end
            // Loaded values above LIMIT are legal; UP folds them straight to zero.
            MODE_UP: begin
                if (acc_q >= LIMIT) begin
                    acc_d  = ZERO;
                    wrap_d = 1'b1;
                end else begin
                    acc_d  = acc_q + ONE;
                end
            end
            MODE_DOWN: begin
                if (acc_q == ZERO) begin
                    acc_d  = LIMIT;
                    wrap_d = 1'b1;
                end else begin
                    acc_d  = acc_q - ONE;
                end
            end
            default: acc_d = acc_q;
        endcase
    end

    // Accumulator advances only on an accepted command.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            acc_q <= ZERO;
        end else if (accept_s) begin
            acc_q <= acc_d;
        end
    end

    // One-entry output stage: occupancy state plus the registered beat.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q    <= OST_EMPTY;
            out_data_q <= ZERO;
            out_sel_q  <= {SELW{1'b0}};
            out_wrap_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            case (state_q)
                OST_EMPTY: state_q <= accept_s ? OST_FULL : OST_EMPTY;
                OST_FULL:  state_q <= (accept_s || !bus.pout_ready) ? OST_FULL : OST_EMPTY;
                default:   state_q <= OST_EMPTY;
            endcase
            if (accept_s) begin
                out_data_q <= acc_d;
                out_sel_q  <= bus.psrc_sel;
                out_wrap_q <= wrap_d;
                out_err_q  <= err_d;
            end
        end
    end

    assign bus.pin_ready  = pin_ready_s;
    assign bus.pout_valid = (state_q == OST_FULL);
    assign bus.pout_data  = out_data_q;
    assign bus.pout_sel   = out_sel_q;
    assign bus.pout_wrap  = out_wrap_q;
    assign bus.pout_err   = out_err_q;

endmodule

// File: tb/tb_chan_load_counter.sv
// Self-checking bench: two configurations (2ch/LIMIT 255 and 3ch/LIMIT 9)
// driven in lockstep and compared against a transaction-level model.
module tb_chan_load_counter;
    import chan_load_pkg::*;

    logic pclk   = 1'b0;
    logic prst_n = 1'b0;
    always #5 pclk = ~pclk;

    chan_load_counter_if #(.WIDTH(8), .CHANNELS(2)) ifa ();
    chan_load_counter_if #(.WIDTH(8), .CHANNELS(3)) ifb ();

    chan_load_counter #(.WIDTH(8), .CHANNELS(2)) dut_a (
        .pclk (pclk), .prst_n (prst_n), .bus (ifa.slave)
    );
    chan_load_counter #(.WIDTH(8), .CHANNELS(3), .LIMIT(8'd9)) dut_b (
        .pclk (pclk), .prst_n (prst_n), .bus (ifb.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model, index 0 = dut_a, 1 = dut_b
    int ch_m   [2] = '{2, 3};
    int lim_m  [2] = '{255, 9};
    int smsk_m [2] = '{1, 3};
    int acc_m  [2];
    bit vld_m  [2];
    int dat_m  [2];
    int sel_m  [2];
    bit wrap_m [2];
    bit err_m  [2];

    logic [7:0] saved;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            vld_m[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [1:0] m,
                              input logic [1:0] s, input bit r, input logic [23:0] src);
        int sl;
        int nw;
        bit wr;
        bit er;
        if (v && (!vld_m[k] || r)) begin
            sl = int'(s) & smsk_m[k];
            nw = acc_m[k];
            wr = 1'b0;
            er = 1'b0;
            case (m)
                2'd1: begin
                    if (sl >= ch_m[k]) begin nw = 0; er = 1'b1; end
                    else nw = int'((src >> (sl * 8)) & 24'hFF);
                end
                2'd2: begin
                    if (acc_m[k] >= lim_m[k]) begin nw = 0; wr = 1'b1; end
                    else nw = acc_m[k] + 1;
                end
                2'd3: begin
                    if (acc_m[k] == 0) begin nw = lim_m[k]; wr = 1'b1; end
                    else nw = acc_m[k] - 1;
                end
                default: nw = acc_m[k];
            endcase
            acc_m[k]  = nw;
            dat_m[k]  = nw;
            sel_m[k]  = sl;
            wrap_m[k] = wr;
            err_m[k]  = er;
            vld_m[k]  = 1'b1;
        end else if (vld_m[k] && r) begin
            vld_m[k] = 1'b0;
        end
    endtask

    task automatic cmp_dut(input int k, input string nm, input logic v, input logic [7:0] d,
                           input logic [1:0] s, input logic w, input logic e);
        check_eq({nm, "_valid"}, 32'(v), 32'(vld_m[k]));
        if (vld_m[k]) begin
            check_eq({nm, "_data"}, 32'(d), 32'(dat_m[k]));
            check_eq({nm, "_sel"},  32'(s), 32'(sel_m[k]));
            check_eq({nm, "_wrap"}, 32'(w), 32'(wrap_m[k]));
            check_eq({nm, "_err"},  32'(e), 32'(err_m[k]));
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input logic [1:0] s,
                         input bit r, input logic [23:0] src);
        ifa.pin_valid  = v;   ifb.pin_valid  = v;
        ifa.pmode      = m;   ifb.pmode      = m;
        ifa.psrc_sel   = s[0]; ifb.psrc_sel  = s;
        ifa.pout_ready = r;   ifb.pout_ready = r;
        ifa.psrc_data  = src[15:0];
        ifb.psrc_data  = src;
    endtask

    // One clock of stimulus: check presented beats, apply inputs, advance model.
    task automatic cycle(input bit v, input logic [1:0] m, input logic [1:0] s,
                         input bit r, input logic [23:0] src);
        cmp_dut(0, "a", ifa.pout_valid, ifa.pout_data, {1'b0, ifa.pout_sel}, ifa.pout_wrap, ifa.pout_err);
        cmp_dut(1, "b", ifb.pout_valid, ifb.pout_data, ifb.pout_sel, ifb.pout_wrap, ifb.pout_err);
        drive(v, m, s, r, src);
        #1;
        check_eq("a_pin_ready", 32'(ifa.pin_ready), 32'(!vld_m[0] || r));
        check_eq("b_pin_ready", 32'(ifb.pin_ready), 32'(!vld_m[1] || r));
        model_step(0, v, m, s, r, src);
        model_step(1, v, m, s, r, src);
        @(posedge pclk);
        @(negedge pclk);
    endtask

    initial begin
        drive(1'b0, 2'd0, 2'd0, 1'b0, 24'h0);
        model_reset();
        #12;
        check_eq("rst_valid", 32'(ifa.pout_valid), 32'd0);
        check_eq("rst_data",  32'(ifa.pout_data),  32'd0);
        check_eq("rst_wrap",  32'(ifb.pout_wrap),  32'd0);
        check_eq("rst_err",   32'(ifb.pout_err),   32'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        #1;
        check_eq("rst_pin_ready", 32'(ifa.pin_ready), 32'd1);

        // LOAD channel 1
        cycle(1'b1, 2'd1, 2'd1, 1'b1, 24'h00A500);
        check_eq("load_a5_data",  32'(ifa.pout_data),  32'hA5);
        check_eq("load_a5_sel",   32'(ifa.pout_sel),   32'd1);
        check_eq("load_a5_valid", 32'(ifa.pout_valid), 32'd1);

        // UP wrap at LIMIT=0xFF
        cycle(1'b1, 2'd1, 2'd0, 1'b1, 24'h0000FE);
        check_eq("fe_data", 32'(ifa.pout_data), 32'hFE);
        cycle(1'b1, 2'd2, 2'd0, 1'b1, 24'h0);
        check_eq("ff_data", 32'(ifa.pout_data), 32'hFF);
        check_eq("ff_wrap", 32'(ifa.pout_wrap), 32'd0);
        cycle(1'b1, 2'd2, 2'd0, 1'b1, 24'h0);
        check_eq("wrap_data", 32'(ifa.pout_data), 32'h00);
        check_eq("wrap_flag", 32'(ifa.pout_wrap), 32'd1);

        // LIMIT=9 boundaries on dut_b
        cycle(1'b1, 2'd1, 2'd0, 1'b1, 24'h000000);
        cycle(1'b1, 2'd3, 2'd0, 1'b1, 24'h0);
        check_eq("down_lim_data", 32'(ifb.pout_data), 32'd9);
        check_eq("down_lim_wrap", 32'(ifb.pout_wrap), 32'd1);
        cycle(1'b1, 2'd1, 2'd0, 1'b1, 24'h00000C);
        check_eq("load12_data", 32'(ifb.pout_data), 32'd12);
        cycle(1'b1, 2'd2, 2'd0, 1'b1, 24'h0);
        check_eq("up12_data", 32'(ifb.pout_data), 32'd0);
        check_eq("up12_wrap", 32'(ifb.pout_wrap), 32'd1);

        // Out-of-range select on the 3-channel instance
        cycle(1'b1, 2'd1, 2'd3, 1'b1, 24'h778899);
        check_eq("oor_data", 32'(ifb.pout_data), 32'd0);
        check_eq("oor_err",  32'(ifb.pout_err),  32'd1);
        cycle(1'b1, 2'd0, 2'd0, 1'b1, 24'h0);
        check_eq("hold_data", 32'(ifb.pout_data), 32'd0);
        check_eq("hold_err",  32'(ifb.pout_err),  32'd0);

        // Backpressure: stall four cycles, then drain back-to-back
        cycle(1'b1, 2'd2, 2'd0, 1'b1, 24'h0);
        saved = ifa.pout_data;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'd2, 2'd0, 1'b0, 24'h0);
            check_eq("bp_stable", 32'(ifa.pout_data), 32'(saved));
            check_eq("bp_pin_ready", 32'(ifa.pin_ready), 32'd0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 2'd0, 1'b1, 24'h0);
        check_eq("bp_resume", 32'(ifa.pout_data), 32'(saved) + 32'd3);

        // Asynchronous reset while FULL
        cycle(1'b1, 2'd1, 2'd0, 1'b1, 24'h000033);
        cycle(1'b0, 2'd0, 2'd0, 1'b0, 24'h0);
        check_eq("pre_rst_data", 32'(ifa.pout_data), 32'h33);
        #2;
        prst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(ifa.pout_valid), 32'd0);
        check_eq("arst_data",  32'(ifa.pout_data),  32'd0);
        check_eq("arst_bvalid", 32'(ifb.pout_valid), 32'd0);
        model_reset();
        @(negedge pclk);
        prst_n = 1'b1;
        #1;
        cycle(1'b1, 2'd0, 2'd0, 1'b1, 24'h0);
        check_eq("post_rst_data",  32'(ifa.pout_data),  32'd0);
        check_eq("post_rst_valid", 32'(ifa.pout_valid), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, 2'($urandom % 4), 2'($urandom % 4),
                  ($urandom % 3) != 0, 24'($urandom));
        end
        cycle(1'b0, 2'd0, 2'd0, 1'b1, 24'h0);
        cycle(1'b0, 2'd0, 2'd0, 1'b1, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chan_load_counter.md
# chan_load_counter

Parametrised, registered successor to the team's 8-bit two-source select/load datapath. Selects one of CHANNELS WIDTH-bit sources and, per accepted command, loads it into an internal accumulator or counts the accumulator up or down with a programmable wrap limit. Every result leaves through a one-entry valid/ready output stage. It sits between the source-select front end and downstream consumers that need backpressure.

## Interface
Parameters:
- WIDTH, 8, data width of each source and of the accumulator (≥2)
- CHANNELS, 2, number of source channels (≥2)
- LIMIT, 2**WIDTH-1, wrap value for counting (≤2**WIDTH-1)
- SELW, max(1,$clog2(CHANNELS)), select width (derived, not overridden)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- pclk  in  1  clock, all state updates on the rising edge
- prst_n  in  1  asynchronous active-low reset
- psrc_data  in  CHANNELS*WIDTH  source channels; channel k is bits [k*WIDTH +: WIDTH]
- psrc_sel  in  SELW  channel select, used by LOAD only
- pmode  in  2  command: 00 HOLD, 01 LOAD, 10 UP, 11 DOWN
- pin_valid  in  1  command valid
- pin_ready  out  1  command accepted when pin_valid & pin_ready
- pout_data  out  WIDTH  accumulator value after the accepted command
- pout_sel  out  SELW  psrc_sel captured with the command
- pout_wrap  out  1  the command wrapped (UP past LIMIT or DOWN past 0)
- pout_err  out  1  LOAD with psrc_sel ≥ CHANNELS
- pout_valid  out  1  output beat valid
- pout_ready  in  1  downstream accepts the beat

## Operation
- The accumulator acc[WIDTH-1:0] changes only on an accepted command.
- HOLD: acc unchanged. A beat is still emitted with wrap=0 and err=0.
- LOAD: acc = channel[psrc_sel]. If psrc_sel ≥ CHANNELS, acc = 0 and err = 1.
- UP: if acc ≥ LIMIT, acc = 0 and wrap = 1; otherwise acc + 1.
- DOWN: if acc == 0, acc = LIMIT and wrap = 1; otherwise acc − 1.
- A loaded value above LIMIT is kept as loaded. The next UP wraps it to 0. The next DOWN decrements it normally.
- Output stage is one register: {data, sel, wrap, err, valid}.
- pin_ready = ~pout_valid | pout_ready (combinational from pout_ready).
- Output stage state:
  - EMPTY: pout_valid = 0. Accept → FULL.
  - FULL: pout_valid = 1. pout_ready with no accept → EMPTY. pout_ready with an accept → FULL with the new beat (back-to-back). No pout_ready → hold all outputs stable and pin_ready = 0.
- pout_data always equals the acc value produced by the beat being presented.

## Timing
- Latency is one cycle: a command accepted at edge n is visible on pout_* after edge n.
- Throughput is one command per cycle while pout_ready = 1.
- Reset values: acc = 0, pout_data = 0, pout_sel = 0, pout_wrap = 0, pout_err = 0, pout_valid = 0, pin_ready = 1 (with reset released).
- Reset mid-operation immediately clears all state. Any in-flight beat is dropped and not replayed.
- Inputs other than pin_valid are don't-care when pin_valid = 0.
- While pout_valid & ~pout_ready, every pout_* output is held bit-stable.

## Structure
- Package chan_load_pkg holds:
  - mode enum: MODE_HOLD = 2'b00, MODE_LOAD = 2'b01, MODE_UP = 2'b10, MODE_DOWN = 2'b11
  - the SELW derivation function
- Sub-module chan_select (combinational, CHANNELS×WIDTH → WIDTH mux). Outputs zero plus an out-of-range flag when sel ≥ CHANNELS.
- Top level holds the accumulator, the next-value logic and the output stage.

## Test plan
- Reset then LOAD with WIDTH=8, sel=1, ch1=0xA5, pout_ready=1 → next cycle pout_data=0xA5, pout_sel=1, wrap=0, err=0, pout_valid=1.
- LOAD 0xFE, then UP, UP with LIMIT=0xFF → beats 0xFE, 0xFF (wrap=0), 0x00 (wrap=1).
- LIMIT=9: LOAD 0, then DOWN → beat 9 with wrap=1. LOAD 12, then UP → beat 0 with wrap=1.
- CHANNELS=3, LOAD with sel=3 → pout_data=0, err=1. Following HOLD → data=0, err=0.
- Backpressure: pout_ready=0 for 4 cycles after one accepted UP → pin_ready=0, outputs stable, acc not advanced. Then pout_ready=1 with pin_valid=1 → back-to-back beats, no loss, no duplication.
- Assert prst_n low while FULL with pout_data=0x33 → pout_valid and pout_data read 0 asynchronously, before the next pclk edge. After release, the first beat reflects acc=0.
